// File: rtl/vga_stream_monitor.sv
// Receive-side VGA stream monitor: recovers pixel coordinates on pix_en, checks line/frame timing,
// tracks lock state and captures the RGB of one probe pixel per frame.
module vga_stream_monitor #(
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_TOTAL  = 525,
    parameter int unsigned V_ACTIVE = 480,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hs,
    input  logic        vs,
    input  logic        blank_n,
    input  logic [23:0] rgb_in,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    output logic        de,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        frame_start,
    output logic        locked,
    output logic        h_err,
    output logic        v_err,
    output logic [7:0]  err_cnt,
    output logic [23:0] probe_rgb,
    output logic        probe_valid
);

    localparam logic [10:0] HT = 11'(H_TOTAL);
    localparam logic [10:0] HA = 11'(H_ACTIVE);
    localparam logic [9:0]  VT = 10'(V_TOTAL);
    localparam logic [9:0]  VA = 10'(V_ACTIVE);

    typedef enum logic [1:0] {ACQUIRE, CHECK, LOCKED} state_e;

    state_e      state_q;
    logic        locked_q, frame_err_q;
    logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [10:0] h_cnt_q, h_cnt_d, act_cnt_q, act_cnt_d, act_cnt_b;
    logic [9:0]  line_idx_q, line_idx_d, line_b;
    logic [9:0]  act_lines_q, act_lines_d, act_lines_b, v_lines_q, v_lines_d;
    logic        line_act_q, line_act_d, line_act_b;
    logic        h_seen_q, h_seen_d, v_seen_q, v_seen_d;
    logic [9:0]  probe_x_l_q, probe_x_l_d, probe_y_l_q, probe_y_l_d;
    logic        de_q, de_d, frame_start_q, frame_start_d;
    logic        h_err_q, h_err_d, v_err_q, v_err_d, probe_valid_q, probe_valid_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [23:0] probe_rgb_q, probe_rgb_d;
    logic        hs_lvl, vs_lvl, hs_asrt, vs_asrt, any_err;

    assign hs_lvl  = (hs == HS_POL);
    assign vs_lvl  = (vs == VS_POL);
    assign hs_asrt = pix_en && hs_lvl && !hs_prev_q;
    assign vs_asrt = pix_en && vs_lvl && !vs_prev_q;
    assign any_err = h_err_d || v_err_d;

    always_comb begin
        hs_prev_d     = hs_prev_q;
        vs_prev_d     = vs_prev_q;
        h_cnt_d       = h_cnt_q;
        act_cnt_d     = act_cnt_q;
        line_idx_d    = line_idx_q;
        act_lines_d   = act_lines_q;
        v_lines_d     = v_lines_q;
        line_act_d    = line_act_q;
        h_seen_d      = h_seen_q;
        v_seen_d      = v_seen_q;
        probe_x_l_d   = probe_x_l_q;
        probe_y_l_d   = probe_y_l_q;
        de_d          = de_q;
        x_d           = x_q;
        y_d           = y_q;
        probe_rgb_d   = probe_rgb_q;
        err_cnt_d     = err_cnt_q;
        frame_start_d = 1'b0;
        h_err_d       = 1'b0;
        v_err_d       = 1'b0;
        probe_valid_d = 1'b0;
        act_cnt_b     = act_cnt_q;
        line_b        = line_idx_q;
        line_act_b    = line_act_q;
        act_lines_b   = act_lines_q;
        if (pix_en) begin
            hs_prev_d = hs_lvl;
            vs_prev_d = vs_lvl;
            h_cnt_d   = (h_cnt_q == '1) ? h_cnt_q : h_cnt_q + 11'd1;
            // Line close runs first; *_b carry the post-line values into frame close and pixel logic.
            if (hs_asrt) begin
                h_err_d    = h_seen_q && ((h_cnt_q != HT) || (line_act_q && act_cnt_q != HA));
                h_cnt_d    = 11'd1;
                act_cnt_b  = '0;
                line_act_b = 1'b0;
                h_seen_d   = 1'b1;
                if (line_act_q) begin
                    line_b      = (line_idx_q == '1) ? line_idx_q : line_idx_q + 10'd1;
                    act_lines_b = (act_lines_q == '1) ? act_lines_q : act_lines_q + 10'd1;
                end
                if (!vs_asrt)
                    v_lines_d = (v_lines_q == '1) ? v_lines_q : v_lines_q + 10'd1;
            end
            if (vs_asrt) begin
                v_err_d       = v_seen_q && ((v_lines_q != VT) || (act_lines_b != VA));
                v_lines_d     = hs_asrt ? 10'd1 : 10'd0;
                line_b        = '0;
                act_lines_b   = '0;
                frame_start_d = 1'b1;
                v_seen_d      = 1'b1;
                probe_x_l_d   = probe_x;
                probe_y_l_d   = probe_y;
            end
            line_idx_d  = line_b;
            act_lines_d = act_lines_b;
            act_cnt_d   = act_cnt_b;
            line_act_d  = line_act_b;
            if (blank_n) begin
                de_d       = 1'b1;
                x_d        = act_cnt_b[9:0];
                y_d        = line_b;
                act_cnt_d  = (act_cnt_b == '1) ? act_cnt_b : act_cnt_b + 11'd1;
                line_act_d = 1'b1;
                if (act_cnt_b == {1'b0, probe_x_l_d} && line_b == probe_y_l_d) begin
                    probe_rgb_d   = rgb_in;
                    probe_valid_d = 1'b1;
                end
            end else begin
                de_d = 1'b0;
            end
        end
        if (any_err && err_cnt_q != '1)
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ACQUIRE;
            locked_q      <= 1'b0;
            frame_err_q   <= 1'b0;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            h_cnt_q       <= '0;
            act_cnt_q     <= '0;
            line_idx_q    <= '0;
            act_lines_q   <= '0;
            v_lines_q     <= '0;
            line_act_q    <= 1'b0;
            h_seen_q      <= 1'b0;
            v_seen_q      <= 1'b0;
            probe_x_l_q   <= '0;
            probe_y_l_q   <= '0;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
            h_err_q       <= 1'b0;
            v_err_q       <= 1'b0;
            err_cnt_q     <= '0;
            probe_rgb_q   <= '0;
            probe_valid_q <= 1'b0;
        end else begin
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            h_cnt_q       <= h_cnt_d;
            act_cnt_q     <= act_cnt_d;
            line_idx_q    <= line_idx_d;
            act_lines_q   <= act_lines_d;
            v_lines_q     <= v_lines_d;
            line_act_q    <= line_act_d;
            h_seen_q      <= h_seen_d;
            v_seen_q      <= v_seen_d;
            probe_x_l_q   <= probe_x_l_d;
            probe_y_l_q   <= probe_y_l_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
            h_err_q       <= h_err_d;
            v_err_q       <= v_err_d;
            err_cnt_q     <= err_cnt_d;
            probe_rgb_q   <= probe_rgb_d;
            probe_valid_q <= probe_valid_d;
            case (state_q)
                ACQUIRE: if (vs_asrt) begin
                    state_q     <= CHECK;
                    frame_err_q <= 1'b0;
                end
                CHECK: if (vs_asrt) begin
                    frame_err_q <= 1'b0;
                    if (!(frame_err_q || any_err)) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                    end
                end else if (any_err) begin
                    frame_err_q <= 1'b1;
                end
                // An error found at the frame boundary belongs to the closed frame, not the new one.
                LOCKED: if (any_err) begin
                    state_q     <= CHECK;
                    locked_q    <= 1'b0;
                    frame_err_q <= !vs_asrt;
                end
                default: begin
                    state_q  <= ACQUIRE;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign h_err       = h_err_q;
    assign v_err       = v_err_q;
    assign err_cnt     = err_cnt_q;
    assign probe_rgb   = probe_rgb_q;
    assign probe_valid = probe_valid_q;

endmodule

// File: tb/tb_vga_stream_monitor.sv
// Directed bench for vga_stream_monitor on a reduced 105x53 raster (101x51 active) so that
// the (100,50) probe lies inside the picture; a second instance sees the inverted-polarity stream.
module tb_vga_stream_monitor;

    localparam int HT = 105, HA = 101, VT = 53, VA = 51;
    localparam int HS_START = 102, HS_END = 103, VS_LINE = 52;

    logic        clk = 1'b0, rst_n = 1'b0, pix_en = 1'b0;
    logic        hs = 1'b1, vs = 1'b1, blank_n = 1'b0;
    logic [23:0] rgb_in = '0;
    logic [9:0]  probe_x = '0, probe_y = '0;
    logic        hs_inv, vs_inv;
    logic        de, frame_start, locked, h_err, v_err, probe_valid;
    logic [9:0]  x, y;
    logic [7:0]  err_cnt;
    logic [23:0] probe_rgb;
    logic        de2, frame_start2, locked2, h_err2, v_err2, probe_valid2;
    logic [9:0]  x2, y2;
    logic [7:0]  err_cnt2;
    logic [23:0] probe_rgb2;

    assign hs_inv = ~hs;
    assign vs_inv = ~vs;

    vga_stream_monitor #(.H_TOTAL(HT), .H_ACTIVE(HA), .V_TOTAL(VT), .V_ACTIVE(VA),
                         .HS_POL(1'b0), .VS_POL(1'b0)) dut (
        .clk(clk), .reset(rst_n), .pix_en(pix_en), .hs(hs), .vs(vs), .blank_n(blank_n),
        .rgb_in(rgb_in), .probe_x(probe_x), .probe_y(probe_y), .de(de), .x(x), .y(y),
        .frame_start(frame_start), .locked(locked), .h_err(h_err), .v_err(v_err),
        .err_cnt(err_cnt), .probe_rgb(probe_rgb), .probe_valid(probe_valid));

    vga_stream_monitor #(.H_TOTAL(HT), .H_ACTIVE(HA), .V_TOTAL(VT), .V_ACTIVE(VA),
                         .HS_POL(1'b1), .VS_POL(1'b1)) dut_pos (
        .clk(clk), .reset(rst_n), .pix_en(pix_en), .hs(hs_inv), .vs(vs_inv), .blank_n(blank_n),
        .rgb_in(rgb_in), .probe_x(probe_x), .probe_y(probe_y), .de(de2), .x(x2), .y(y2),
        .frame_start(frame_start2), .locked(locked2), .h_err(h_err2), .v_err(v_err2),
        .err_cnt(err_cnt2), .probe_rgb(probe_rgb2), .probe_valid(probe_valid2));

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int n_herr, n_verr, n_pv, n_fs, max_x, max_y, min_x, min_y;
    bit chk_en = 1'b0, half_rate = 1'b0;
    logic       exp_de = 1'b0;
    logic [9:0] exp_x = '0, exp_y = '0;

    always @(negedge clk) begin
        if (h_err) n_herr++;
        if (v_err) n_verr++;
        if (probe_valid) n_pv++;
        if (frame_start) n_fs++;
        if (de) begin
            if (int'(x) > max_x) max_x = int'(x);
            if (int'(x) < min_x) min_x = int'(x);
            if (int'(y) > max_y) max_y = int'(y);
            if (int'(y) < min_y) min_y = int'(y);
        end
    end

    task automatic clear_counts();
        n_herr = 0; n_verr = 0; n_pv = 0; n_fs = 0;
        max_x = -1; max_y = -1; min_x = 100000; min_y = 100000;
    endtask

    task automatic stop_stream();
        @(negedge clk);
        pix_en = 1'b0;
        #1;
    endtask

    task automatic drive_pixel(input int ln, input int px);
        logic bl;
        bl = (ln < VA) && (px < HA);
        if (half_rate) begin
            @(negedge clk);
            pix_en  = 1'b0;
            hs      = 1'($urandom);
            vs      = 1'($urandom);
            blank_n = 1'($urandom);
            rgb_in  = 24'($urandom);
            @(posedge clk);
            #1;
            if (chk_en) begin
                vectors++;
                if ({de, x, y} !== {exp_de, exp_x, exp_y}) begin
                    miscompares++;
                    $display("FAIL idle_hold L%0d P%0d: de/x/y got %0b/%0d/%0d expected %0b/%0d/%0d",
                             ln, px, de, x, y, exp_de, exp_x, exp_y);
                end
            end
        end
        @(negedge clk);
        pix_en  = 1'b1;
        hs      = (px >= HS_START && px <= HS_END) ? 1'b0 : 1'b1;
        vs      = (ln == VS_LINE) ? 1'b0 : 1'b1;
        blank_n = bl;
        rgb_in  = {8'(px), 8'(ln), 8'hA5};
        @(posedge clk);
        #1;
        if (bl) begin
            exp_de = 1'b1;
            exp_x  = 10'(px);
            exp_y  = 10'(ln);
        end else begin
            exp_de = 1'b0;
        end
        if (chk_en) begin
            vectors++;
            if ({de, x, y} !== {exp_de, exp_x, exp_y}) begin
                miscompares++;
                $display("FAIL pixel L%0d P%0d: de/x/y got %0b/%0d/%0d expected %0b/%0d/%0d",
                         ln, px, de, x, y, exp_de, exp_x, exp_y);
            end
        end
    endtask

    task automatic drive_line(input int ln, input int len);
        for (int p = 0; p < len; p++) drive_pixel(ln, p);
    endtask

    // Lines 0..VT-1; VS asserts at the start of the last line, closing the frame inside the task.
    task automatic run_frame(input int short_line, input int skip_line);
        for (int l = 0; l < VT; l++) begin
            if (l != skip_line) drive_line(l, (l == short_line) ? HT - 1 : HT);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pix_en = 1'b1; hs = 1'b0; vs = 1'b0; blank_n = 1'b1; rgb_in = 24'hFFFFFF;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({de, x, y, frame_start, locked, h_err, v_err, err_cnt, probe_rgb, probe_valid} !== 58'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {de, x, y, frame_start, locked, h_err, v_err, err_cnt, probe_rgb, probe_valid});
        end
        vectors++;
        if ({de2, x2, y2, frame_start2, locked2, h_err2, v_err2, err_cnt2, probe_rgb2, probe_valid2} !== 58'd0) begin
            miscompares++;
            $display("FAIL reset_outputs_pos: got %h expected 0",
                     {de2, x2, y2, frame_start2, locked2, h_err2, v_err2, err_cnt2, probe_rgb2, probe_valid2});
        end
        @(negedge clk);
        pix_en = 1'b0; hs = 1'b1; vs = 1'b1; blank_n = 1'b0; rgb_in = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        probe_x = 10'd100; probe_y = 10'd50;
        chk_en = 1'b1;
        clear_counts();
        drive_line(VS_LINE, HT);
        vectors++;
        if (locked !== 1'b0 || n_fs != 1) begin
            miscompares++;
            $display("FAIL nominal_first_vs: locked/frames got %0b/%0d expected 0/1", locked, n_fs);
        end
        run_frame(-1, -1);
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("FAIL nominal_lock_2nd_vs: locked got %0b expected 1", locked);
        end
        run_frame(-1, -1);
        run_frame(-1, -1);
        stop_stream();
        vectors++;
        if (locked !== 1'b1 || err_cnt !== 8'd0 || n_herr != 0 || n_verr != 0) begin
            miscompares++;
            $display("FAIL nominal_clean: locked/err_cnt/h_err/v_err got %0b/%0d/%0d/%0d expected 1/0/0/0",
                     locked, err_cnt, n_herr, n_verr);
        end
        vectors++;
        if (min_x != 0 || max_x != HA - 1 || min_y != 0 || max_y != VA - 1) begin
            miscompares++;
            $display("FAIL nominal_span: x %0d..%0d y %0d..%0d expected x 0..%0d y 0..%0d",
                     min_x, max_x, min_y, max_y, HA - 1, VA - 1);
        end
        vectors++;
        if (n_pv != 3 || probe_rgb !== 24'h6432A5) begin
            miscompares++;
            $display("FAIL nominal_probe: pulses/rgb got %0d/%h expected 3/6432a5", n_pv, probe_rgb);
        end
        vectors++;
        if (n_fs != 4) begin
            miscompares++;
            $display("FAIL nominal_frame_start: got %0d expected 4", n_fs);
        end
        vectors++;
        if (locked2 !== 1'b1 || err_cnt2 !== 8'd0 || probe_rgb2 !== 24'h6432A5) begin
            miscompares++;
            $display("FAIL pos_polarity: locked/err_cnt/rgb got %0b/%0d/%h expected 1/0/6432a5",
                     locked2, err_cnt2, probe_rgb2);
        end
    endtask

    task automatic test_bad_line();
        clear_counts();
        run_frame(10, -1);
        stop_stream();
        vectors++;
        if (n_herr != 1 || n_verr != 0 || err_cnt !== 8'd1 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_line: h_err/v_err/err_cnt/locked got %0d/%0d/%0d/%0b expected 1/0/1/0",
                     n_herr, n_verr, err_cnt, locked);
        end
        run_frame(-1, -1);
        stop_stream();
        vectors++;
        if (locked !== 1'b1 || n_herr != 1 || err_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL bad_line_relock: locked/h_err/err_cnt got %0b/%0d/%0d expected 1/1/1",
                     locked, n_herr, err_cnt);
        end
    endtask

    task automatic test_short_frame();
        probe_x = 10'd700; probe_y = 10'd10;
        clear_counts();
        run_frame(-1, VT - 2);
        stop_stream();
        vectors++;
        if (n_verr != 1 || n_herr != 0 || err_cnt !== 8'd2 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL short_frame: v_err/h_err/err_cnt/locked got %0d/%0d/%0d/%0b expected 1/0/2/0",
                     n_verr, n_herr, err_cnt, locked);
        end
        vectors++;
        if (n_pv != 1) begin
            miscompares++;
            $display("FAIL short_frame_probe: pulses got %0d expected 1", n_pv);
        end
        clear_counts();
        run_frame(-1, -1);
        stop_stream();
        vectors++;
        if (n_pv != 0 || probe_rgb !== 24'h6432A5) begin
            miscompares++;
            $display("FAIL probe_outside: pulses/rgb got %0d/%h expected 0/6432a5", n_pv, probe_rgb);
        end
        probe_x = 10'd100; probe_y = 10'd50;
        run_frame(-1, -1);
        stop_stream();
        vectors++;
        if (locked !== 1'b1 || n_verr != 0 || err_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL short_frame_relock: locked/v_err/err_cnt got %0b/%0d/%0d expected 1/0/2",
                     locked, n_verr, err_cnt);
        end
    endtask

    task automatic test_half_rate();
        half_rate = 1'b1;
        clear_counts();
        run_frame(-1, -1);
        stop_stream();
        half_rate = 1'b0;
        vectors++;
        if (locked !== 1'b1 || n_herr != 0 || n_verr != 0 || err_cnt !== 8'd2 || n_fs != 1) begin
            miscompares++;
            $display("FAIL half_rate: locked/h_err/v_err/err_cnt/frames got %0b/%0d/%0d/%0d/%0d expected 1/0/0/2/1",
                     locked, n_herr, n_verr, err_cnt, n_fs);
        end
        vectors++;
        if (n_pv != 1 || probe_rgb !== 24'h6432A5 || max_x != HA - 1 || max_y != VA - 1) begin
            miscompares++;
            $display("FAIL half_rate_probe_span: pulses/rgb/max_x/max_y got %0d/%h/%0d/%0d expected 1/6432a5/%0d/%0d",
                     n_pv, probe_rgb, max_x, max_y, HA - 1, VA - 1);
        end
    endtask

    task automatic test_reset_midframe();
        for (int l = 0; l < 20; l++) drive_line(l, HT);
        for (int p = 0; p < 50; p++) drive_pixel(20, p);
        #2;
        rst_n = 1'b0;
        pix_en = 1'b0;
        #1;
        vectors++;
        if ({de, x, y, frame_start, locked, h_err, v_err, err_cnt, probe_rgb, probe_valid} !== 58'd0) begin
            miscompares++;
            $display("FAIL reset_midline: got %h expected 0",
                     {de, x, y, frame_start, locked, h_err, v_err, err_cnt, probe_rgb, probe_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b0;
        clear_counts();
        for (int p = 50; p < HT; p++) drive_pixel(20, p);
        for (int l = 21; l < VT; l++) drive_line(l, HT);
        stop_stream();
        vectors++;
        if (n_herr != 0 || n_verr != 0 || locked !== 1'b0 || n_fs != 1) begin
            miscompares++;
            $display("FAIL reset_partial: h_err/v_err/locked/frames got %0d/%0d/%0b/%0d expected 0/0/0/1",
                     n_herr, n_verr, locked, n_fs);
        end
        chk_en = 1'b1;
        run_frame(-1, -1);
        stop_stream();
        vectors++;
        if (locked !== 1'b1 || err_cnt !== 8'd0 || n_herr != 0 || n_verr != 0) begin
            miscompares++;
            $display("FAIL reset_relock: locked/err_cnt/h_err/v_err got %0b/%0d/%0d/%0d expected 1/0/0/0",
                     locked, err_cnt, n_herr, n_verr);
        end
        vectors++;
        if (locked2 !== 1'b1 || err_cnt2 !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_relock_pos: locked/err_cnt got %0b/%0d expected 1/0", locked2, err_cnt2);
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_counts();
        test_reset();
        test_nominal();
        test_bad_line();
        test_short_frame();
        test_half_rate();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
